uart_tx_fifo: RTL

Parametrised UART transmit engine with an input FIFO. It serialises DATA_BITS-wide words LSB-first with a configurable baud divisor, optional odd/even parity and one or two stop bits. It accepts words through a valid/ready handshake, buffers up to FIFO_DEPTH of them, and sends buffered words back-to-back with no idle gap. It replaces the fixed 8N1 one-bit-per-clock transmitter in the matrix-result readout path.

---
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small input FIFO: LSB-first frames with optional
// parity and one or two stop bits, sent back-to-back while words are buffered.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [DATA_BITS-1:0]            in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            out,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST  = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 1 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadParams
    $error("uart_tx_fifo: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q;
  logic [BW-1:0]        baudCnt_q;
  logic [3:0]           bitIdx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q, out_q, busy_q, done_q;
  logic [AW-1:0]        wrPtr_q, rdPtr_q;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head;
  logic                 push, pop, bitEnd, frameEnd, headParity;

  assign head       = mem_q[rdPtr_q];
  assign in_ready   = (count_q != FULL_COUNT);
  assign push       = in_valid && in_ready;
  assign bitEnd     = en && (baudCnt_q == BAUD_LAST);
  assign frameEnd   = bitEnd && (state_q == S_STOP) && (bitIdx_q == STOP_LAST);
  assign pop        = en && (count_q != '0) && ((state_q == S_IDLE) || frameEnd);
  assign headParity = (PARITY == 1) ? ~^head : ^head;

  assign out        = out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_count = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wrPtr_q] <= in_data;
  end

  // A pop always launches a START bit, whether from IDLE or straight out of the last stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      out_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
    end else begin
      count_q <= count_d;
      done_q  <= frameEnd;
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop) begin
        rdPtr_q   <= rdPtr_q + 1'b1;
        shift_q   <= head;
        parity_q  <= headParity;
        state_q   <= S_START;
        baudCnt_q <= '0;
        bitIdx_q  <= '0;
        out_q     <= 1'b0;
        busy_q    <= 1'b1;
      end else if (state_q == S_IDLE) begin
        out_q  <= 1'b1;
        busy_q <= 1'b0;
      end else if (en) begin
        if (!bitEnd) begin
          baudCnt_q <= baudCnt_q + 1'b1;
        end else begin
          baudCnt_q <= '0;
          case (state_q)
            S_START: begin
              state_q  <= S_DATA;
              bitIdx_q <= '0;
              out_q    <= shift_q[0];
            end
            S_DATA: begin
              if (bitIdx_q == DATA_LAST) begin
                bitIdx_q <= '0;
                if (PARITY != 0) begin
                  state_q <= S_PARITY;
                  out_q   <= parity_q;
                end else begin
                  state_q <= S_STOP;
                  out_q   <= 1'b1;
                end
              end else begin
                bitIdx_q <= bitIdx_q + 4'd1;
                shift_q  <= shift_q >> 1;
                out_q    <= shift_q[1];
              end
            end
            S_PARITY: begin
              state_q  <= S_STOP;
              bitIdx_q <= '0;
              out_q    <= 1'b1;
            end
            S_STOP: begin
              if (bitIdx_q == STOP_LAST) begin
                state_q <= S_IDLE;
                out_q   <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                bitIdx_q <= bitIdx_q + 4'd1;
              end
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end
    end
  end
endmodule
